// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART blocks
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE_DEF = 8;
  localparam int DATA_BITS_DEF  = 8;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with selectable reset value
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic nreset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, oversampled bit timing, valid/ack holding register
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF     = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] LAST     = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_t            state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [BW-1:0]        bitidx, bitidx_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 armed, armed_d;
  logic                 rxd_s;
  logic                 done;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk    (clk),
    .nreset (nreset),
    .d      (rxd),
    .q      (rxd_s)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state  <= IDLE;
      cnt    <= '0;
      bitidx <= '0;
      shreg  <= '0;
      armed  <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      bitidx <= bitidx_d;
      shreg  <= shreg_d;
      armed  <= armed_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    bitidx_d = bitidx;
    shreg_d  = shreg;
    armed_d  = armed;
    if (tick) begin
      case (state)
        // armed only after a high sample, so a held-low line cannot retrigger
        IDLE: begin
          if (rxd_s) begin
            armed_d = 1'b1;
          end else if (armed) begin
            state_d = START;
            cnt_d   = CW'(1);
          end
        end
        START: begin
          cnt_d = cnt + 1'b1;
          if (cnt_d == HALF) begin
            if (rxd_s) begin
              state_d = IDLE;
            end else begin
              state_d  = DATA;
              cnt_d    = '0;
              bitidx_d = '0;
            end
          end
        end
        DATA: begin
          cnt_d = cnt + 1'b1;
          if (cnt == LAST) begin
            shreg_d  = {rxd_s, shreg[DATA_BITS-1:1]};
            bitidx_d = bitidx + 1'b1;
            if (bitidx == LAST_BIT) state_d = STOP;
          end
        end
        STOP: begin
          cnt_d = cnt + 1'b1;
          if (cnt == LAST) begin
            state_d = IDLE;
            armed_d = rxd_s;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
    done = tick && (state == STOP) && (cnt == LAST);
  end

  // an ack landing on the completion cycle frees the register for the new byte
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (done && (!rx_valid || rx_ack)) begin
      rx_data   <= shreg;
      frame_err <= ~rxd_s;
      rx_valid  <= 1'b1;
      if (rx_valid) overrun <= 1'b0;
    end else if (done) begin
      overrun <= 1'b1;
    end else if (rx_ack && rx_valid) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: 8N1 serial frames are sampled from rxd and delivered as bytes through a valid/ack holding register.
- Timing comes from the 8x oversampling tick produced by baudgen's baud_fast output, which is a single-cycle pulse every ~54.25 clocks at 50 MHz.
- Sits between the board rxd pin and the byte consumer. It is the receive-side counterpart of baudgen-driven transmit logic.

Parameters:
- OVERSAMPLE, 8: ticks per bit; must be a power of two, minimum 4.
- DATA_BITS, 8: data bits per frame, LSB first.

Ports:
- clk  input  1  system clock, 50 MHz nominal.
- nreset  input  1  asynchronous, active-low reset.
- tick  input  1  single-cycle pulse at OVERSAMPLE x baud rate (baud_fast); must always be driven (baudgen enable tied high).
- rxd  input  1  asynchronous serial line; idle high.
- rx_data  output  DATA_BITS  last received byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ack  input  1  consumer takes the byte; only meaningful while rx_valid=1.
- frame_err  output  1  stop bit of the byte in rx_data sampled low.
- overrun  output  1  sticky; a completed byte was dropped because rx_valid was still set.
- busy  output  1  FSM not in IDLE.

Behaviour:
- One clock domain; all flops reset asynchronously on nreset=0.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, sync flops=1.
- rxd passes through a 2-flop synchronizer (rxd_s). All decisions use rxd_s.
- The FSM and tick counter (log2(OVERSAMPLE) bits) advance only on cycles where tick=1.
- States:
  - IDLE:
    - Arming: requires one tick with rxd_s=1 after reset or after a frame error. This blocks break/stuck-low re-triggering.
    - When armed, tick with rxd_s=0 -> START, cnt=1.
  - START:
    - Each tick increments cnt.
    - At the tick where cnt reaches OVERSAMPLE/2 (bit centre), sample rxd_s.
    - rxd_s=1 -> false start; return to IDLE (still armed), no output.
    - rxd_s=0 -> DATA, cnt=0, bitidx=0.
  - DATA:
    - Sample every OVERSAMPLE ticks (at cnt wrap).
    - Shift the sample into a shift register, LSB first.
    - After DATA_BITS samples -> STOP.
  - STOP:
    - After OVERSAMPLE ticks, sample the stop bit, then perform completion.
    - Go to IDLE immediately, without waiting for the end of the stop bit.
    - If stop=0, IDLE is disarmed.
- Completion, registered, visible the clk after the stop-sample tick:
  - If rx_valid=0, or rx_ack=1 in the same cycle: load rx_data, set frame_err=~stop, set rx_valid=1.
  - Otherwise: drop the byte, set overrun=1. rx_data and frame_err are unchanged.
- Ack:
  - rx_ack=1 with rx_valid=1 and no simultaneous completion -> rx_valid=0 the next clk.
  - overrun is cleared by that ack unless a drop occurs in the same cycle; a drop wins.
  - rx_ack while rx_valid=0 is ignored.
- busy=1 in every state except IDLE.
- Reset mid-frame: the partial byte is discarded and no rx_valid is produced. The receiver rearms once rxd_s=1 is seen.
- Latency: falling edge on rxd to rx_valid is about 9.5 bit times plus up to 1 tick of detection jitter plus 3 clks.

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum rx_state_t {IDLE, START, DATA, STOP}
  - localparam OVERSAMPLE_DEF=8 and DATA_BITS_DEF=8
  - function clog2 helper, if needed by the toolchain
- One natural sub-module: sync2. It is a 2-flop synchronizer with a reset value parameter, reset to 1 here, and is reusable by future UART blocks.

Test Plan:
- Byte receive: tick every 54 clks, rxd drives 0xA5 as 8N1 at 8 ticks/bit -> rx_data=0xA5, rx_valid=1, frame_err=0, overrun=0; busy falls after the stop sample.
- False start: rxd low for 2 ticks, then high -> no rx_valid; busy pulses and returns to 0. A following 0x3C frame is received correctly.
- Frame error: 0x3C with the stop bit driven low, then line high for 2 bit times -> rx_data=0x3C, frame_err=1. No new start is detected until rxd has been sampled high.
- Overrun:
  - 0x11, then 0x22 back-to-back, no ack -> rx_data=0x11, overrun=1.
  - Ack -> rx_valid=0, overrun=0.
- Ack collision: rx_ack asserted on the exact cycle the second byte 0x22 completes -> rx_data=0x22, rx_valid stays 1, overrun=0.
- Reset mid-frame: nreset low during bit 3 of 0xFF, then released with the line idle -> all outputs 0. The next frame 0x5A is received correctly.
